// File: rtl/cpu_latent_wb_arbiter_pkg.sv
// Shared constants and types for the latent write-back arbiter.
// Source encodings, the latent entry layout and the round-robin step.
package cpu_latent_wb_arbiter_pkg;

  localparam logic [1:0] WB_SRC_MEM = 2'd0;
  localparam logic [1:0] WB_SRC_DIV = 2'd1;
  localparam logic [1:0] WB_SRC_FPU = 2'd2;

  localparam int N_SRC   = 3;
  localparam int ENTRY_W = 37;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic [1:0] rr_next(input logic [1:0] src);
    return (src == WB_SRC_FPU) ? WB_SRC_MEM : src + 2'd1;
  endfunction

endpackage

// File: rtl/cpu_latent_wb_arbiter_if.sv
// Bus bundle between the latent result sources, the COM slot and the arbiter.
// Signal prefixes are from the arbiter's point of view.
interface cpu_latent_wb_arbiter_if;

  logic [4:0]  i_p5_alu_dest;
  logic        i_mem_valid;
  logic        o_mem_ready;
  logic [4:0]  i_mem_dest;
  logic [31:0] i_mem_data;
  logic        i_div_valid;
  logic        o_div_ready;
  logic [4:0]  i_div_dest;
  logic [31:0] i_div_data;
  logic        i_fpu_valid;
  logic        o_fpu_ready;
  logic [4:0]  i_fpu_dest;
  logic [31:0] i_fpu_data;
  logic        o_wb_valid;
  logic [1:0]  o_wb_src;
  logic [4:0]  o_wb_dest;
  logic [31:0] o_wb_data;
  logic        o_sb_clear;
  logic [4:0]  o_sb_clear_dest;
  logic        o_hold_issue;

  modport slave (
    input  i_p5_alu_dest,
    input  i_mem_valid, i_mem_dest, i_mem_data,
    input  i_div_valid, i_div_dest, i_div_data,
    input  i_fpu_valid, i_fpu_dest, i_fpu_data,
    output o_mem_ready, o_div_ready, o_fpu_ready,
    output o_wb_valid, o_wb_src, o_wb_dest, o_wb_data,
    output o_sb_clear, o_sb_clear_dest, o_hold_issue
  );

  modport master (
    output i_p5_alu_dest,
    output i_mem_valid, i_mem_dest, i_mem_data,
    output i_div_valid, i_div_dest, i_div_data,
    output i_fpu_valid, i_fpu_dest, i_fpu_data,
    input  o_mem_ready, o_div_ready, o_fpu_ready,
    input  o_wb_valid, o_wb_src, o_wb_dest, o_wb_data,
    input  o_sb_clear, o_sb_clear_dest, o_hold_issue
  );

endinterface

// File: rtl/cpu_latent_wb_arbiter_fifo.sv
// Small circular holding FIFO for one latent result source.
// Head is read straight from storage so it is visible the cycle after a push.
module cpu_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
      assert (!(i_pop && o_empty));
      assert (!(i_push && o_full));
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/cpu_latent_wb_arbiter.sv
// Shares the COM-stage write slot among the load, divider and FPU result FIFOs.
// Round-robin grant, scoreboard clear, starvation tracking and issue hold.
module cpu_latent_wb_arbiter
  import cpu_latent_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic clock,
  input logic reset,
  cpu_latent_wb_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

  logic [N_SRC-1:0] w_in_valid;
  logic [N_SRC-1:0] w_ready;
  logic [N_SRC-1:0] w_push;
  logic [N_SRC-1:0] w_pop;
  logic [N_SRC-1:0] w_full;
  logic [N_SRC-1:0] w_empty;
  wb_entry_t        w_in_entry [N_SRC];
  wb_entry_t        w_head     [N_SRC];
  logic [CW-1:0]    w_count    [N_SRC];
  logic [CW-1:0]    w_cnt_nxt  [N_SRC];
  logic [SW-1:0]    w_starve_nxt [N_SRC];

  logic [SW-1:0]    r_starve [N_SRC];
  logic [1:0]       r_rr;
  logic             r_hold_issue;

  logic             w_slot_free;
  logic             w_any;
  logic [1:0]       w_grant;
  logic [1:0]       w_c0, w_c1, w_c2;
  logic             w_wb_valid;
  logic             w_hold_nxt;
  wb_entry_t        w_sel;

  assign w_in_valid    = {bus.i_fpu_valid, bus.i_div_valid, bus.i_mem_valid};
  assign w_in_entry[0] = {bus.i_mem_dest, bus.i_mem_data};
  assign w_in_entry[1] = {bus.i_div_dest, bus.i_div_data};
  assign w_in_entry[2] = {bus.i_fpu_dest, bus.i_fpu_data};

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    // Ready comes from the registered count only; a dest-0 push is accepted but dropped.
    assign w_ready[g] = !reset && !w_full[g];
    assign w_push[g]  = w_in_valid[g] && w_ready[g] && (w_in_entry[g].dest != 5'd0);

    cpu_wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push[g]),
      .i_din   (w_in_entry[g]),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_count (w_count[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  assign bus.o_mem_ready = w_ready[0];
  assign bus.o_div_ready = w_ready[1];
  assign bus.o_fpu_ready = w_ready[2];

  always_comb begin
    w_c0    = r_rr;
    w_c1    = rr_next(w_c0);
    w_c2    = rr_next(w_c1);
    w_any   = 1'b1;
    w_grant = w_c0;
    if (!w_empty[w_c0])      w_grant = w_c0;
    else if (!w_empty[w_c1]) w_grant = w_c1;
    else if (!w_empty[w_c2]) w_grant = w_c2;
    else                     w_any   = 1'b0;
  end

  // Outputs are suppressed during reset so dropped entries never clear the scoreboard.
  assign w_slot_free = (bus.i_p5_alu_dest == 5'd0);
  assign w_wb_valid  = !reset && w_slot_free && w_any;
  assign w_pop       = w_wb_valid ? (3'b001 << w_grant) : 3'b000;
  assign w_sel       = w_head[w_grant];

  assign bus.o_wb_valid      = w_wb_valid;
  assign bus.o_wb_src        = w_wb_valid ? w_grant : 2'd0;
  assign bus.o_wb_dest       = w_wb_valid ? w_sel.dest : 5'd0;
  assign bus.o_wb_data       = w_wb_valid ? w_sel.data : 32'd0;
  assign bus.o_sb_clear      = w_wb_valid;
  assign bus.o_sb_clear_dest = bus.o_wb_dest;
  assign bus.o_hold_issue    = r_hold_issue;

  always_comb begin
    w_hold_nxt = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      w_cnt_nxt[i] = w_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      if (w_empty[i] || w_pop[i])      w_starve_nxt[i] = '0;
      else if (r_starve[i] == STARVE_C) w_starve_nxt[i] = r_starve[i];
      else                              w_starve_nxt[i] = r_starve[i] + 1'b1;
      if (w_cnt_nxt[i] == DEPTH_C || w_starve_nxt[i] == STARVE_C) w_hold_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr         <= WB_SRC_MEM;
      r_hold_issue <= 1'b0;
      for (int i = 0; i < N_SRC; i++) r_starve[i] <= '0;
    end else begin
      if (w_wb_valid) r_rr <= rr_next(w_grant);
      r_hold_issue <= w_hold_nxt;
      for (int i = 0; i < N_SRC; i++) r_starve[i] <= w_starve_nxt[i];
      assert (!w_wb_valid || bus.i_p5_alu_dest == 5'd0);
    end
  end

endmodule
